// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Holds the fetch FSM state enum, the default NOP word and the misalign test.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry register slice between fetch and decode.
// Ports: clk/rst, load_i + payload (inst/pc/misalign), drain_i, clear_i,
// and valid_o/inst_o/pc_o/mis_o toward decode.
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               AW       = 32,
    parameter logic [XLEN-1:0]  NOP_INST = NOP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [AW-1:0]   pc_i,
    input  logic            mis_i,
    input  logic            drain_i,
    input  logic            clear_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [AW-1:0]   pc_o,
    output logic            mis_o
);

    logic            valid_q;
    logic [XLEN-1:0] inst_q;
    logic [AW-1:0]   pc_q;
    logic            mis_q;

    // Clear wins over load; load wins over drain so a same-cycle
    // load and drain leaves the new entry valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            mis_q   <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            mis_q   <= mis_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign mis_o   = mis_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: single-outstanding word request to imem,
// one-entry buffer toward decode, and PC-advance pulse to the PC register.
// Ports: clk/rst, pc/pc_advance, flush, imem_* request/response,
// id_valid/id_ready/id_inst/id_pc/id_misalign toward decode.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               AW       = 32,
    parameter logic [XLEN-1:0]  NOP_INST = NOP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   pc,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [AW-1:0]   id_pc,
    output logic            id_misalign
);

    fetch_state_e    state_q, state_d;
    logic [AW-1:0]   req_pc_q, req_pc_d;

    logic            buf_free;
    logic            ld;
    logic [XLEN-1:0] ld_inst;
    logic [AW-1:0]   ld_pc;
    logic            ld_mis;

    assign buf_free = !id_valid || id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        pc_advance = 1'b0;
        ld         = 1'b0;
        ld_inst    = NOP_INST;
        ld_pc      = pc;
        ld_mis     = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (!flush && buf_free) begin
                    if (is_misaligned(pc[1:0])) begin
                        // Misaligned PC never reaches memory; decode
                        // gets a tagged NOP so it can raise the trap.
                        ld         = 1'b1;
                        ld_mis     = 1'b1;
                        pc_advance = 1'b1;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_gnt) begin
                            pc_advance = 1'b1;
                            req_pc_d   = pc;
                            state_d    = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    ld      = !flush;
                    ld_inst = imem_rdata;
                    ld_pc   = req_pc_q;
                    state_d = REQ;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = imem_req ? {pc[AW-1:2], 2'b00} : '0;

    fetch_buf #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NOP_INST (NOP_INST)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ld),
        .inst_i  (ld_inst),
        .pc_i    (ld_pc),
        .mis_i   (ld_mis),
        .drain_i (id_valid && id_ready),
        .clear_i (flush),
        .valid_o (id_valid),
        .inst_o  (id_inst),
        .pc_o    (id_pc),
        .mis_o   (id_misalign)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run against a queue-based model of accepted fetches and a toy memory.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_misalign;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_misalign (id_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        flush       = 1'b0;
    endtask

    // Leaves the DUT in cycle 0 (IDLE) with rst low.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pc = 32'h0;
        do_reset();
        rst = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_advance !== 1'b0
            || id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0
            || id_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h adv=%b v=%b inst=%h pc=%h mis=%b",
                     imem_req, imem_addr, pc_advance, id_valid, id_inst,
                     id_pc, id_misalign);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: req=%b expected 0", imem_req);
        end
    endtask

    task automatic test_first_fetch();
        pc = 32'h0;
        do_reset();
        step();
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || pc_advance !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_grant: req=%b adv=%b addr=%h expected 1 1 0",
                     imem_req, pc_advance, imem_addr);
        end
        step();
        pc          = 32'h4;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_advance !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: req=%b adv=%b v=%b expected 0 0 0",
                     imem_req, pc_advance, id_valid);
        end
        step();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093 || id_pc !== 32'h0
            || id_misalign !== 1'b0) begin
            errors++;
            $display("FAIL first_data: v=%b inst=%h pc=%h mis=%b expected 1 00500093 0 0",
                     id_valid, id_inst, id_pc, id_misalign);
        end
    endtask

    task automatic test_stall_grant();
        pc = 32'h10;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_advance !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: req=%b addr=%h adv=%b expected 1 10 0",
                         i, imem_req, imem_addr, pc_advance);
            end
            step();
        end
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (pc_advance !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_grant: adv=%b addr=%h expected 1 10",
                     pc_advance, imem_addr);
        end
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        step();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'hCAFE_0001 || id_pc !== 32'h10) begin
            errors++;
            $display("FAIL stall_data: v=%b inst=%h pc=%h expected 1 cafe0001 10",
                     id_valid, id_inst, id_pc);
        end
    endtask

    task automatic test_backpressure();
        pc = 32'h0;
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        pc          = 32'h4;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b0 || id_valid !== 1'b1
                || id_inst !== 32'h1111_1111 || id_pc !== 32'h0) begin
                errors++;
                $display("FAIL bp_hold_%0d: req=%b v=%b inst=%h pc=%h expected 0 1 11111111 0",
                         i, imem_req, id_valid, id_inst, id_pc);
            end
            step();
        end
        id_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL bp_release: req=%b addr=%h expected 1 4",
                     imem_req, imem_addr);
        end
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_flush();
        pc = 32'h20;
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        pc       = 32'h40;
        #1;
        checks++;
        if (pc_advance !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_comb: adv=%b req=%b expected 0 0",
                     pc_advance, imem_req);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: req=%b v=%b expected 0 0", imem_req, id_valid);
        end
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_valid === 1'b1 && id_inst === 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL flush_stale_%0d: inst=%h delivered", i, id_inst);
            end
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL flush_redirect: req=%b addr=%h expected 1 40",
                             imem_req, imem_addr);
                end
            end
            step();
        end
    endtask

    task automatic test_misalign();
        pc = 32'h6;
        do_reset();
        step();
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_advance !== 1'b1) begin
            errors++;
            $display("FAIL mis_issue: req=%b adv=%b expected 0 1", imem_req, pc_advance);
        end
        step();
        pc = 32'hA;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_inst !== NOP || id_pc !== 32'h6
            || id_misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis_entry: v=%b inst=%h pc=%h mis=%b expected 1 13 6 1",
                     id_valid, id_inst, id_pc, id_misalign);
        end
    endtask

    task automatic test_reset_in_wait();
        pc = 32'h8;
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_advance !== 1'b0
            || id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0
            || id_misalign !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: req=%b addr=%h adv=%b v=%b inst=%h pc=%h mis=%b",
                     imem_req, imem_addr, pc_advance, id_valid, id_inst,
                     id_pc, id_misalign);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: req=%b expected 0", imem_req);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL rst_req: req=%b addr=%h expected 1 8", imem_req, imem_addr);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    // Every accepted fetch (pc_advance) must reach decode once, in order,
    // unless a flush discards it first.
    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] next_pc;
        logic [31:0] mem_addr;
        logic        pend;
        int          cnt;
        int          consumed;
        pc = 32'h100;
        do_reset();
        pend     = 1'b0;
        cnt      = 0;
        mem_addr = 32'h0;
        consumed = 0;
        next_pc  = pc;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pc          = next_pc;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(mem_addr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_gnt = ($urandom_range(0, 2) != 0);
            id_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            #1;
            if (id_valid && id_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: cyc=%0d inst=%h pc=%h", cyc, id_inst, id_pc);
                end else begin
                    e = q.pop_front();
                    consumed++;
                    if (id_inst !== e.inst || id_pc !== e.pc || id_misalign !== e.mis) begin
                        errors++;
                        $display("FAIL rnd_data: cyc=%0d got %h/%h/%b expected %h/%h/%b",
                                 cyc, id_inst, id_pc, id_misalign, e.inst, e.pc, e.mis);
                    end
                end
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== {pc[31:2], 2'b00} || pend) begin
                    errors++;
                    $display("FAIL rnd_req: cyc=%0d addr=%h pc=%h outstanding=%b",
                             cyc, imem_addr, pc, pend);
                end
                if (imem_gnt) begin
                    pend     = 1'b1;
                    cnt      = $urandom_range(1, 3);
                    mem_addr = imem_addr;
                end
            end
            if (pc_advance) begin
                checks++;
                if (flush) begin
                    errors++;
                    $display("FAIL rnd_adv_flush: cyc=%0d advance during flush", cyc);
                end
                e.pc   = pc;
                e.mis  = (pc[1:0] != 2'b00);
                e.inst = e.mis ? NOP : memf({pc[31:2], 2'b00});
                q.push_back(e);
                if ($urandom_range(0, 7) == 0) next_pc = $urandom & 32'h0000_FFFF;
                else next_pc = pc + 32'h4;
            end
            if (flush) begin
                q.delete();
                next_pc = $urandom & 32'h0000_FFFC;
                if ($urandom_range(0, 3) == 0) next_pc[1:0] = 2'b10;
            end
            step();
        end
        checks++;
        if (consumed < 100) begin
            errors++;
            $display("FAIL rnd_progress: consumed=%0d expected >=100", consumed);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        pc  = 32'h0;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_stall_grant();
        test_backpressure();
        test_flush();
        test_misalign();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
